ysyx_220053_ifu: RTL

- Instruction fetch unit. Generates the PC stream, issues word requests to instruction memory and buffers the returned 32-bit instructions.
- Presents instructions with their PC to the decode stage over a valid/ready handshake.
- The decoder is the consumer of this block. It raises a halt on an environment trap and drives redirects on jumps and taken branches.

---
 rtl/ysyx_220053_pkg.sv | 24 ++
 rtl/ysyx_220053_ifu_fifo.sv | 54 +++++
 rtl/ysyx_220053_ifu.sv | 104 ++++++++++
 3 files changed

// File: rtl/ysyx_220053_pkg.sv
// ysyx_220053_pkg: shared widths, reset PC, FSM encoding and buffer entry type of the fetch unit
package ysyx_220053_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] DEF_RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            fault;
    } ifu_entry_t;

    // Instruction fetches are always word aligned; low two bits are cleared.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/ysyx_220053_ifu_fifo.sv
// ysyx_220053_ifu_fifo: synchronous instruction buffer with flush and occupancy count
module ysyx_220053_ifu_fifo import ysyx_220053_pkg::*; #(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush_i,
    input  logic       push_i,
    input  ifu_entry_t data_i,
    input  logic       pop_i,
    output ifu_entry_t data_o,
    output logic       empty_o,
    output logic [AW:0] count_o
);

    ifu_entry_t    mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && cnt_q != '0;
    assign do_push = push_i && !flush_i && (cnt_q < (AW+1)'(DEPTH) || do_pop);

    // Pointer and count update; a flush empties the buffer regardless of push/pop.
    always_comb begin
        rd_d  = flush_i ? '0 : rd_q + AW'(do_pop);
        wr_d  = flush_i ? '0 : wr_q + AW'(do_push);
        cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: an entry is only observed after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/ysyx_220053_ifu.sv
// ysyx_220053_ifu: instruction fetch unit with credit-limited requests, redirect dropping and halt drain
module ysyx_220053_ifu import ysyx_220053_pkg::*; #(
    parameter logic [63:0] RESET_PC   = DEF_RESET_PC,
    parameter int          FIFO_DEPTH = 2,
    parameter int          CNT_W      = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            fault_o,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt_i,
    output logic            halted_o
);

    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = (CNT_W > CW ? CNT_W : CW) + 1;

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] out_q, out_d, drop_q, drop_d;
    logic [XLEN-1:0] redirect_tgt;
    logic            redirect_take, credit, req_fire, push, pop;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    ifu_entry_t      push_entry, head;

    // A redirect only acts while running and loses to a simultaneous halt.
    assign redirect_take = state_q == RUN && redirect_valid && !halt_i;
    assign redirect_tgt  = word_align(redirect_pc);

    // Every in-flight request already owns a buffer slot, so responses never find the FIFO full.
    assign credit         = SUM_W'(out_q) + SUM_W'(fifo_count) < SUM_W'(FIFO_DEPTH);
    assign imem_req_valid = rst_n && state_q == RUN && !redirect_valid && credit;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Stale responses (pending drops, or one arriving with a redirect) never reach the buffer.
    assign push       = imem_rsp_valid && drop_q == '0 && !redirect_take;
    assign pop        = instr_valid && instr_ready;
    assign push_entry = '{instr: imem_rsp_data, pc: resp_pc_q, fault: imem_rsp_err};

    ysyx_220053_ifu_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_take),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign instr_valid = !fifo_empty;
    assign instr_o     = instr_valid ? head.instr : '0;
    assign pc_o        = instr_valid ? head.pc : '0;
    assign fault_o     = instr_valid && head.fault;
    assign halted_o    = state_q == HALTED && out_q == '0 && fifo_empty;

    // Next state: FSM, fetch/response PCs, outstanding and drop counters.
    always_comb begin
        state_d    = (state_q == RUN && halt_i) ? HALTED : state_q;
        fetch_pc_d = req_fire ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
        resp_pc_d  = push ? resp_pc_q + XLEN'(4) : resp_pc_q;
        out_d      = out_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        drop_d     = drop_q - CNT_W'(imem_rsp_valid && drop_q != '0);
        if (redirect_take) begin
            fetch_pc_d = redirect_tgt;
            resp_pc_d  = redirect_tgt;
            drop_d     = out_q - CNT_W'(imem_rsp_valid);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

endmodule
